// File: rtl/alarm_ringer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_ringer: gated square-wave buzzer sequencer with stop/snooze/timeout  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alarm_ringer #(
   parameter int unsigned HALF_P1      = 25000,
   parameter int unsigned HALF_P2      = 12500,
   parameter int unsigned BEAT_CYC     = 12500000,
   parameter int unsigned RING_BEATS   = 120,
   parameter int unsigned SNOOZE_BEATS = 1200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] alarm_up_clk,
   input  logic [4:0] key,
   output logic       beep,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] ring_tone
);

   localparam int unsigned HALF_MAX  = (HALF_P1 > HALF_P2) ? HALF_P1 : HALF_P2;
   localparam int unsigned BEATS_MAX = (RING_BEATS > SNOOZE_BEATS) ? RING_BEATS : SNOOZE_BEATS;
   localparam int TW = $clog2(HALF_MAX + 1);
   localparam int BW = $clog2(BEAT_CYC + 1);
   localparam int IW = $clog2(BEATS_MAX + 1);

   localparam logic [TW-1:0] HALF1_LAST  = TW'(HALF_P1 - 1);
   localparam logic [TW-1:0] HALF2_LAST  = TW'(HALF_P2 - 1);
   localparam logic [BW-1:0] BEAT_LAST   = BW'(BEAT_CYC - 1);
   localparam logic [IW-1:0] RING_LAST   = IW'(RING_BEATS - 1);
   localparam logic [IW-1:0] SNOOZE_LAST = IW'(SNOOZE_BEATS - 1);

   // State bit 0 doubles as ringing, bit 1 as snoozing.
   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_RING   = 2'b01;
   localparam logic [1:0] ST_SNOOZE = 2'b10;

   logic [1:0]    state_q, state_d;
   logic [1:0]    tone_q, tone_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          sq_q, sq_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [IW-1:0] bidx_q, bidx_d;

   logic          w_trigger;
   logic          w_beat_wrap;
   logic [TW-1:0] w_half_last;
   logic          w_gate;
   logic          w_clear;
   logic          w_unused_keys;

   assign w_trigger     = |alarm_up_clk;
   assign w_beat_wrap   = (bcnt_q == BEAT_LAST);
   assign w_half_last   = (tone_q == 2'b10) ? HALF2_LAST : HALF1_LAST;
   assign w_unused_keys = ^key[4:2];

   // Later assignments override earlier ones: timeout < snooze < stop < trigger.
   always_comb begin
      state_d = state_q;
      tone_d  = tone_q;
      tcnt_d  = tcnt_q;
      sq_d    = sq_q;
      bcnt_d  = bcnt_q;
      bidx_d  = bidx_q;
      w_clear = 1'b0;
      case (state_q)
         ST_RING: begin
            if (tcnt_q == w_half_last) begin
               tcnt_d = '0;
               sq_d   = ~sq_q;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
            if (w_beat_wrap) begin
               bcnt_d = '0;
               if (bidx_q == RING_LAST) begin
                  state_d = ST_IDLE;
                  tone_d  = 2'b00;
                  w_clear = 1'b1;
               end else begin
                  bidx_d = bidx_q + 1'b1;
               end
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
            if (key[1]) begin
               state_d = ST_SNOOZE;
               tone_d  = tone_q;
               w_clear = 1'b1;
            end
            if (key[0]) begin
               state_d = ST_IDLE;
               tone_d  = 2'b00;
               w_clear = 1'b1;
            end
         end
         ST_SNOOZE: begin
            if (w_beat_wrap) begin
               bcnt_d = '0;
               if (bidx_q == SNOOZE_LAST) begin
                  state_d = ST_RING;
                  w_clear = 1'b1;
               end else begin
                  bidx_d = bidx_q + 1'b1;
               end
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
            if (key[0]) begin
               state_d = ST_IDLE;
               tone_d  = 2'b00;
               w_clear = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tone_d  = 2'b00;
            w_clear = 1'b1;
         end
      endcase
      if (w_trigger) begin
         state_d = ST_RING;
         tone_d  = alarm_up_clk[0] ? 2'b01 : 2'b10;
         w_clear = 1'b1;
      end
      if (w_clear) begin
         tcnt_d = '0;
         sq_d   = 1'b0;
         bcnt_d = '0;
         bidx_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tone_q  <= 2'b00;
         tcnt_q  <= '0;
         sq_q    <= 1'b0;
         bcnt_q  <= '0;
         bidx_q  <= '0;
      end else begin
         state_q <= state_d;
         tone_q  <= tone_d;
         tcnt_q  <= tcnt_d;
         sq_q    <= sq_d;
         bcnt_q  <= bcnt_d;
         bidx_q  <= bidx_d;
      end
   end

   // Tone 1 alternates beats on/off; tone 2 sounds two beats, rests two.
   assign w_gate    = tone_q[0] ? ~bidx_q[0] : ~bidx_q[1];
   assign ringing   = state_q[0];
   assign snoozing  = state_q[1];
   assign ring_tone = tone_q;
   assign beep      = sq_q & w_gate & ringing;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ringer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alarm_ringer: directed bench for alarm_ringer                           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alarm_ringer;

   localparam int HP1 = 4;
   localparam int HP2 = 2;
   localparam int BC  = 32;
   localparam int RB  = 8;
   localparam int SB  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] alarm_up_clk = 2'b00;
   logic [4:0] key = 5'b00000;
   logic       beep;
   logic       ringing;
   logic       snoozing;
   logic [1:0] ring_tone;

   int checks = 0;
   int errors = 0;

   alarm_ringer #(
      .HALF_P1     (HP1),
      .HALF_P2     (HP2),
      .BEAT_CYC    (BC),
      .RING_BEATS  (RB),
      .SNOOZE_BEATS(SB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alarm_up_clk(alarm_up_clk),
      .key         (key),
      .beep        (beep),
      .ringing     (ringing),
      .snoozing    (snoozing),
      .ring_tone   (ring_tone)
   );

   always #5 clk = ~clk;

   // Expected beep k cycles after ring entry.
   function automatic logic exp_beep(input logic [1:0] tone, input int k);
      int   half;
      logic sq;
      logic gate;
      half = (tone == 2'b10) ? HP2 : HP1;
      sq   = ((k / half) % 2) == 1;
      gate = (tone == 2'b10) ? (((k / BC) / 2) % 2 == 0) : ((k / BC) % 2 == 0);
      return sq & gate;
   endfunction

   task automatic trigger(input logic [1:0] v);
      @(negedge clk);
      alarm_up_clk = v;
      @(negedge clk);
      alarm_up_clk = 2'b00;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({beep, ringing, snoozing, ring_tone} !== 5'b0) begin
         errors++;
         $display("FAIL reset outputs got=%b want=00000", {beep, ringing, snoozing, ring_tone});
      end
      rst = 1'b0;
   endtask

   task automatic test_tone1_timeout;
      trigger(2'b01);
      for (int k = 0; k < RB * BC; k++) begin
         checks++;
         if (ringing !== 1'b1 || snoozing !== 1'b0 || ring_tone !== 2'b01) begin
            errors++;
            $display("FAIL tone1_state k=%0d ringing=%b snoozing=%b tone=%b want 1/0/01", k, ringing, snoozing, ring_tone);
         end
         checks++;
         if (beep !== exp_beep(2'b01, k)) begin
            errors++;
            $display("FAIL tone1_beep k=%0d got=%b want=%b", k, beep, exp_beep(2'b01, k));
         end
         @(negedge clk);
      end
      checks++;
      if ({beep, ringing, snoozing, ring_tone} !== 5'b0) begin
         errors++;
         $display("FAIL tone1_timeout got=%b want=00000", {beep, ringing, snoozing, ring_tone});
      end
   endtask

   task automatic test_tone2_gating;
      trigger(2'b10);
      for (int k = 0; k < RB * BC; k++) begin
         checks++;
         if (ringing !== 1'b1 || ring_tone !== 2'b10) begin
            errors++;
            $display("FAIL tone2_state k=%0d ringing=%b tone=%b want 1/10", k, ringing, ring_tone);
         end
         checks++;
         if (beep !== exp_beep(2'b10, k)) begin
            errors++;
            $display("FAIL tone2_beep k=%0d got=%b want=%b", k, beep, exp_beep(2'b10, k));
         end
         @(negedge clk);
      end
      checks++;
      if ({beep, ringing, ring_tone} !== 4'b0) begin
         errors++;
         $display("FAIL tone2_timeout got=%b want=0000", {beep, ringing, ring_tone});
      end
   endtask

   task automatic test_simultaneous;
      trigger(2'b11);
      checks++;
      if (ringing !== 1'b1 || ring_tone !== 2'b01) begin
         errors++;
         $display("FAIL simul_tone ringing=%b tone=%b want 1/01", ringing, ring_tone);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (beep !== 1'b1) begin
         errors++;
         $display("FAIL simul_beep got=%b want=1", beep);
      end
      key = 5'b00001;
      @(negedge clk);
      key = 5'b00000;
   endtask

   task automatic test_stop;
      trigger(2'b01);
      repeat (20) @(negedge clk);
      key = 5'b11100;
      @(negedge clk);
      key = 5'b00000;
      checks++;
      if (ringing !== 1'b1 || beep !== exp_beep(2'b01, 21)) begin
         errors++;
         $display("FAIL ignored_keys ringing=%b beep=%b want 1/%b", ringing, beep, exp_beep(2'b01, 21));
      end
      repeat (28) @(negedge clk);
      key = 5'b00001;
      @(negedge clk);
      key = 5'b00000;
      checks++;
      if ({beep, ringing, snoozing, ring_tone} !== 5'b0) begin
         errors++;
         $display("FAIL stop got=%b want=00000", {beep, ringing, snoozing, ring_tone});
      end
      key = 5'b00010;
      @(negedge clk);
      key = 5'b00000;
      checks++;
      if ({ringing, snoozing} !== 2'b00) begin
         errors++;
         $display("FAIL idle_snooze_key got=%b want=00", {ringing, snoozing});
      end
   endtask

   task automatic test_snooze;
      trigger(2'b10);
      repeat (39) @(negedge clk);
      key = 5'b00010;
      @(negedge clk);
      for (int j = 0; j < SB * BC; j++) begin
         checks++;
         if (snoozing !== 1'b1 || ringing !== 1'b0 || beep !== 1'b0 || ring_tone !== 2'b10) begin
            errors++;
            $display("FAIL snooze_hold j=%0d snz=%b ring=%b beep=%b tone=%b want 1/0/0/10", j, snoozing, ringing, beep, ring_tone);
         end
         key = (j == 60) ? 5'b00010 : 5'b00000;
         @(negedge clk);
      end
      key = 5'b00000;
      for (int m = 0; m < 16; m++) begin
         checks++;
         if (ringing !== 1'b1 || snoozing !== 1'b0 || ring_tone !== 2'b10) begin
            errors++;
            $display("FAIL snooze_return m=%0d ring=%b snz=%b tone=%b want 1/0/10", m, ringing, snoozing, ring_tone);
         end
         checks++;
         if (beep !== exp_beep(2'b10, m)) begin
            errors++;
            $display("FAIL snooze_rering_beep m=%0d got=%b want=%b", m, beep, exp_beep(2'b10, m));
         end
         @(negedge clk);
      end
      key = 5'b00010;
      @(negedge clk);
      key = 5'b00000;
      checks++;
      if (snoozing !== 1'b1 || ringing !== 1'b0) begin
         errors++;
         $display("FAIL snooze_again snz=%b ring=%b want 1/0", snoozing, ringing);
      end
      repeat (10) @(negedge clk);
      key = 5'b00001;
      @(negedge clk);
      key = 5'b00000;
      checks++;
      if ({beep, ringing, snoozing, ring_tone} !== 5'b0) begin
         errors++;
         $display("FAIL snooze_stop got=%b want=00000", {beep, ringing, snoozing, ring_tone});
      end
   endtask

   task automatic test_collisions;
      trigger(2'b10);
      repeat (10) @(negedge clk);
      alarm_up_clk = 2'b01;
      key          = 5'b00001;
      @(negedge clk);
      alarm_up_clk = 2'b00;
      key          = 5'b00000;
      for (int m = 0; m < 9; m++) begin
         checks++;
         if (ringing !== 1'b1 || ring_tone !== 2'b01 || beep !== exp_beep(2'b01, m)) begin
            errors++;
            $display("FAIL trig_vs_stop m=%0d ring=%b tone=%b beep=%b want 1/01/%b", m, ringing, ring_tone, beep, exp_beep(2'b01, m));
         end
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (beep !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_beep got=%b want=1", beep);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({beep, ringing, snoozing, ring_tone} !== 5'b0) begin
         errors++;
         $display("FAIL mid_ring_reset got=%b want=00000", {beep, ringing, snoozing, ring_tone});
      end
      repeat (8) @(negedge clk);
      checks++;
      if ({beep, ringing, snoozing, ring_tone} !== 5'b0) begin
         errors++;
         $display("FAIL post_reset_idle got=%b want=00000", {beep, ringing, snoozing, ring_tone});
      end
   endtask

   initial begin
      test_reset();
      test_tone1_timeout();
      test_tone2_gating();
      test_simultaneous();
      test_stop();
      test_snooze();
      test_collisions();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alarm_ringer.md
# alarm_ringer

Buzzer sequencer that sits directly downstream of the alarm compare block. It takes that block's one-cycle ring-start pulses (`alarm_up_clk[1:0]`, one bit per ring tone) and the debounced key pulses, and drives the board buzzer with a gated square-wave ring pattern. It supports stop, snooze with automatic re-ring, and a ring timeout. It also reports ring and snooze status to the display and LED logic.

## Interface
Parameters (all counts in `clk` cycles or beats):
- `HALF_P1`, default 25000, half-period of tone 1 (1 kHz at 50 MHz).
- `HALF_P2`, default 12500, half-period of tone 2 (2 kHz).
- `BEAT_CYC`, default 12500000, length of one beat (0.25 s).
- `RING_BEATS`, default 120, ring timeout in beats (30 s).
- `SNOOZE_BEATS`, default 1200, snooze length in beats (5 min).

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `alarm_up_clk`  in  2  one-cycle start pulses; bit0 selects tone 1, bit1 selects tone 2.
- `key`  in  5  one-cycle debounced key pulses; `key[0]` = stop, `key[1]` = snooze; `key[4:2]` are ignored.
- `beep`  out  1  buzzer drive.
- `ringing`  out  1  high while in RING.
- `snoozing`  out  1  high while in SNOOZE.
- `ring_tone`  out  2  active tone: 2'b01 = tone 1, 2'b10 = tone 2, 2'b00 in IDLE; held during SNOOZE.

## Operation
- States: IDLE, RING, SNOOZE.
- **Trigger.** A trigger is any nonzero `alarm_up_clk` sample.
  - If both bits are set, tone 1 wins.
  - A trigger in any state enters RING with the new tone.
  - On entry, the tone counter, square level, beat counter and beat index all clear to 0.
  - A trigger during RING restarts the ring.
- **RING behaviour.**
  - The tone counter counts 0..HALF_Px−1. At wrap, the square level `sq` toggles.
  - The beat counter counts 0..BEAT_CYC−1. At wrap, the beat index `bidx` increments.
  - Gate: tone 1 sounds when `bidx[0]==0` (on/off beats). Tone 2 sounds when `bidx[1]==0` (two on, two off).
  - `beep = sq & gate & ringing`. Both `sq` and `bidx` are registers.
- **RING exits.**
  - `key[0]` → IDLE.
  - `key[1]` → SNOOZE; the beat counter and index clear.
  - Beat index reaches RING_BEATS → IDLE (no automatic snooze).
- **SNOOZE behaviour.**
  - `beep` stays 0 and beats are counted.
  - Beat index reaches SNOOZE_BEATS → RING with the held tone, all counters cleared.
  - `key[0]` → IDLE, and `ring_tone` clears.
  - `key[1]` is ignored.
- **IDLE:** keys are ignored.
- **Priority in the same cycle:** trigger > stop > snooze > timeout.
- **Widths.** Counters use `$clog2` of their terminal value + 1. There is no wrap past a terminal value; the terminal value forces the state transition.
- **Reset.** Synchronous reset forces IDLE with all counters at 0. Reset mid-ring silences `beep` at the next edge.

## Timing
- All outputs are registered or an AND of registers. Reset values: `beep`=0, `ringing`=0, `snoozing`=0, `ring_tone`=2'b00.
- **Trigger latency.** Trigger sampled at edge E0 → `ringing`=1 and `ring_tone` valid after E0.
- **First sound.** `sq` first goes high after edge E0+HALF_Px, so the first `beep` high is HALF_Px cycles after entry. Square period is 2·HALF_Px.
- **Ring timeout.** `ringing` falls after edge E0+RING_BEATS·BEAT_CYC.
- **Key latency.** A stop or snooze key sampled at edge E changes state after E. `beep` is 0 from that point.
- **Snooze return.** `snoozing` rises after the key edge Es. It falls, and `ringing` rises, after edge Es+SNOOZE_BEATS·BEAT_CYC.

## Test plan
Bench parameters: HALF_P1=4, HALF_P2=2, BEAT_CYC=32, RING_BEATS=8, SNOOZE_BEATS=4.

1. **Tone 1, timeout.** Pulse `alarm_up_clk`=2'b01 at E0.
   - `ringing`=1, `ring_tone`=01.
   - `beep` is an 8-cycle-period square, first high after E4, during beats 0/2/4/6 only.
   - `ringing`=0 after E256.
2. **Tone 2 gating.** Pulse 2'b10.
   - 4-cycle square present during cycles 0–63 and 128–191, silent during 64–127 and 192–255.
3. **Simultaneous trigger.** Pulse 2'b11 → `ring_tone`=01.
4. **Stop.** `key[0]` at E50 → `ringing`=0, `beep`=0 and `ring_tone`=00 after E50.
5. **Snooze.** `key[1]` at E40 during a tone-2 ring.
   - `snoozing`=1, `beep`=0, `ring_tone`=10.
   - After E168, `ringing`=1 again with `beep` restarting from phase 0.
   - `key[0]` during a later snooze → IDLE.
6. **Collisions.**
   - Trigger 2'b01 and `key[0]` in the same cycle while ringing tone 2 → ring restarts with tone 01.
   - `rst` asserted mid-ring → all outputs 0 after the next edge.
